// File: rtl/fpsqrt_frac_arb_pkg.sv
// Shared widths and FSM encoding for the sqrt-fraction arbiter.
package fpsqrt_frac_arb_pkg;

    localparam int FP_OP_W  = 53;
    localparam int FP_RES_W = 54;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/fpsqrt_frac_rr_pick.sv
// Combinational round-robin picker: search starts one past the last grant and wraps.
module fpsqrt_frac_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic               any_o,
    output logic [ID_W-1:0]    idx_o,
    output logic [NUM_REQ-1:0] onehot_o
);

    logic [ID_W-1:0] cand;

    always_comb begin
        any_o    = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        cand     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(last_i) + i) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpsqrt_frac_arb.sv
// Round-robin sequencer sharing one iterative sqrt-fraction unit among NUM_REQ requesters.
module fpsqrt_frac_arb
    import fpsqrt_frac_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int OP_W    = FP_OP_W,
    parameter  int RES_W   = FP_RES_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0][OP_W-1:0]  req_op_i,
    input  logic [NUM_REQ-1:0]            req_is_odd_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    input  logic [NUM_REQ-1:0]            rsp_ready_i,
    output logic [RES_W-1:0]              rsp_res_o,
    output logic                          sq_start_valid_o,
    input  logic                          sq_start_ready_i,
    output logic [OP_W-1:0]               sq_op_o,
    output logic                          sq_is_odd_o,
    output logic                          sq_flush_o,
    input  logic                          sq_finish_valid_i,
    output logic                          sq_finish_ready_o,
    input  logic [RES_W-1:0]              sq_res_i,
    output logic                          busy_o,
    output logic [ID_W-1:0]               owner_o
);

    arb_state_t       state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             is_odd_q, is_odd_d;
    logic [RES_W-1:0] res_q, res_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  last_q, last_d;

    logic               pick_any;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               req_fire;

    fpsqrt_frac_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i    (req_valid_i),
        .last_i   (last_q),
        .any_o    (pick_any),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    // A flush gates the grant so no operand is latched in the flushing cycle.
    assign req_ready_o = (state_q == IDLE && !flush_i) ? pick_onehot : '0;
    assign req_fire    = (state_q == IDLE) && !flush_i && pick_any;

    assign sq_start_valid_o  = (state_q == ISSUE);
    assign sq_op_o           = op_q;
    assign sq_is_odd_o       = is_odd_q;
    assign sq_flush_o        = flush_i;
    assign sq_finish_ready_o = (state_q == WAIT) && sq_finish_valid_i;

    assign rsp_valid_o = (state_q == RESP) ? (NUM_REQ'(1) << owner_q) : '0;
    assign rsp_res_o   = res_q;
    assign busy_o      = (state_q != IDLE);
    assign owner_o     = owner_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        is_odd_d = is_odd_q;
        res_d    = res_q;
        owner_d  = owner_q;
        last_d   = last_q;
        unique case (state_q)
            IDLE: begin
                if (req_fire) begin
                    op_d     = req_op_i[pick_idx];
                    is_odd_d = req_is_odd_i[pick_idx];
                    owner_d  = pick_idx;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (sq_start_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (sq_finish_valid_i) begin
                    res_d   = sq_res_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush drops any finish or response in flight and keeps the pointer.
        if (flush_i) begin
            state_d = IDLE;
            res_d   = res_q;
            last_d  = last_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            is_odd_q <= 1'b0;
            res_q    <= '0;
            owner_q  <= '0;
            last_q   <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            is_odd_q <= is_odd_d;
            res_q    <= res_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
        end
    end

endmodule
